imem_loader: RTL and testbench

Serial program loader for the Hack instruction memory. Accepts a byte stream (from the UART receiver, valid/ready handshake), assembles 16-bit Hack instructions, writes them into a 256 x 16 instruction RAM, and holds the CPU in reset until the image is complete. It sits in front of the CPU's instruction port as a writable replacement for the preloaded boot image: `instruction = mem[pc[7:0]]`.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_ram.sv | 26 ++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the serial Hack instruction-memory loader.
// Loader FSM states, RAM geometry and the byte-acceptance decode.
package imem_loader_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;
    localparam int MAX_WORDS  = 256;

    typedef enum logic [2:0] {
        CNT_HI  = 3'd0,
        CNT_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_e;

    // Every state that still expects image bytes takes one per cycle.
    function automatic logic accepts_byte(state_e s);
        return s inside {CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK};
    endfunction

endpackage

// File: rtl/imem_ram.sv
// 256 x 16 instruction RAM: one synchronous write port, one async read port.
// Contents survive reset; only the loader ever writes them.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [15:0]        wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [15:0]        rdata
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the Hack instruction RAM; holds the CPU in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [15:0] pc,
    output logic [15:0] instruction,
    output logic        cpu_rst_n,
    output logic        load_error,
    output logic [8:0]  words_loaded
);

    state_e             state_q, state_d;
    logic [7:0]         cnt_hi_q, cnt_hi_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [7:0]         hi_q, hi_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [8:0]         words_q, words_d;
    logic               accept;
    logic               we;
    logic [15:0]        count_w;
    logic               last_w;
    logic               unused_pc;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e END_ST = CHECK;
    logic [7:0] xor_q, xor_d;
`else
    localparam state_e END_ST = DONE;
`endif

    assign rx_ready     = accepts_byte(state_q);
    assign cpu_rst_n    = (state_q == DONE);
    assign load_error   = (state_q == ERROR);
    assign words_loaded = words_q;
    assign accept       = rx_valid && rx_ready;
    assign count_w      = {cnt_hi_q, rx_data};
    assign last_w       = (words_q + 9'd1) == cnt_q;
    assign unused_pc    = ^pc[15:8];

    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        words_d  = words_q;
        we       = 1'b0;
        case (state_q)
            CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = rx_data;
                    state_d  = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d = count_w[8:0];
                    if (count_w > 16'(MAX_WORDS)) begin
                        state_d = ERROR;
                    end else if (count_w == 16'd0) begin
                        state_d = END_ST;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    we      = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    words_d = words_q + 9'd1;
                    state_d = last_w ? END_ST : DATA_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = (rx_data == xor_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CNT_HI;
            cnt_hi_q <= 8'h00;
            cnt_q    <= 9'd0;
            hi_q     <= 8'h00;
            addr_q   <= '0;
            words_q  <= 9'd0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // The checksum byte itself is not folded into the running XOR.
    always_comb begin
        xor_d = xor_q;
        if (accept && state_q != CHECK) begin
            xor_d = xor_q ^ rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xor_q <= 8'h00;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q),
        .wdata ({hi_q, rx_data}),
        .raddr (pc[IMEM_AW-1:0]),
        .rdata (instruction)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed image loads plus randomized
// images compared against a word-level model of the expected RAM image.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        cpu_rst_n;
    logic        load_error;
    logic [8:0]  words_loaded;

    int vecs;
    int errs;

    logic [15:0] ref_mem   [256];
    bit          ref_known [256];
    logic [15:0] img [$];

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_rst_n    (cpu_rst_n),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_words", words_loaded, 0);
    endtask

    // Offer one byte at a negedge; it is consumed on the following posedge.
    task automatic put(input logic [7:0] b, input int gap);
        chk("rx_ready_load", rx_ready, 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // gm: 0 = valid held high, 1 = toggled, 2 = random idle gaps.
    task automatic load(input int n, input int gm, input bit bad_ck);
        logic [7:0] q [$];
        logic [7:0] x;
        bit         err;
        int         nw;
        int         gap;
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        err = (n > 256);
        nw  = err ? 0 : n;
        for (int i = 0; i < nw; i++) begin
            q.push_back(img[i][15:8]);
            q.push_back(img[i][7:0]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!err) begin
            x = 8'h00;
            foreach (q[i]) x = x ^ q[i];
            if (bad_ck) x = (x == 8'h00) ? 8'h01 : 8'h00;
            q.push_back(x);
            err = bad_ck;
        end
`else
        x = 8'h00;
        if (bad_ck) $display("note: checksum disabled, corruption ignored");
`endif
        for (int k = 0; k < q.size(); k++) begin
            gap = (gm == 0) ? 0 : (gm == 1) ? 1 : int'($urandom_range(0, 2));
            if (k == q.size() - 1) begin
                chk("cpu_rst_n_early", cpu_rst_n, 0);
                gap = 0;
            end
            put(q[k], gap);
        end
        chk("end_cpu_rst_n", cpu_rst_n, {31'd0, !err});
        chk("end_load_error", load_error, {31'd0, err});
        chk("end_rx_ready", rx_ready, 0);
        chk("end_words", words_loaded, nw);
        rx_data = x ^ 8'hA5;
        repeat (2) @(negedge clk);
        chk("hold_rx_ready", rx_ready, 0);
        chk("hold_words", words_loaded, nw);
        chk("hold_cpu_rst_n", cpu_rst_n, {31'd0, !err});
        rx_valid = 1'b0;
        for (int i = 0; i < nw; i++) begin
            ref_mem[i]   = img[i];
            ref_known[i] = 1'b1;
        end
    endtask

    task automatic verify_ram();
        for (int i = 0; i < 256; i++) begin
            if (ref_known[i]) begin
                @(negedge clk);
                pc = {8'($urandom), 8'(i)};
                #1;
                chk($sformatf("instr[%0d]", i), instruction, ref_mem[i]);
            end
        end
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(16'($urandom));
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 16'h0000;
        for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;

        do_reset();

        img = '{16'hFC10, 16'hE308};
        load(2, 0, 1'b0);
        @(negedge clk);
        pc = 16'h0001;
        #1 chk("pc1_instr", instruction, 16'hE308);
        verify_ram();

        do_reset();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(16'(i));
        load(256, 0, 1'b0);
        verify_ram();

        do_reset();
        load(257, 0, 1'b0);
        verify_ram();

        do_reset();
        rand_img(2);
        load(2, 1, 1'b0);
        verify_ram();

        do_reset();
        put(8'h00, 0);
        put(8'h02, 0);
        put(8'hAB, 0);
        do_reset();
        img = '{16'h1234};
        load(1, 0, 1'b0);
        verify_ram();

        do_reset();
        load(0, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 24);
            rand_img(n);
            load(n, $urandom_range(0, 2), 1'b0);
            verify_ram();
        end

        do_reset();
        load($urandom_range(257, 65535), 2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        img = '{16'h1234};
        load(1, 0, 1'b1);
        do_reset();
        rand_img(5);
        load(5, 2, 1'b1);
        verify_ram();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
